// File: rtl/apb_reg_slave.sv
// APB register slave with CTRL, SCRATCH, STATUS and WCOUNT and programmable wait states.
// Define APB_REG_SLAVE_PSLVERR_EN to flag unmapped accesses and read-only writes on pslverr_o.
module apb_reg_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic                  pwrite_i,
   input  logic [31:0]           pwdata_i,
   output logic [31:0]           prdata_o,
   output logic                  pready_o,
   output logic                  pslverr_o,
   input  logic [31:0]           status_i,
   output logic [31:0]           ctrl_o
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state, state_nx;
   logic [3:0]  wait_cnt, wait_cnt_nx;
   logic [31:0] ctrl, scratch, wcount;
   logic [31:0] rdata;
   logic [1:0]  idx;
   logic        mapped;
   logic        done;
   logic        wr_en;

   assign idx    = paddr_i[3:2];
   assign mapped = (paddr_i >> 4) == '0;

   assign pready_o = (state == ACCESS) && psel_i && penable_i
                     && (wait_cnt == 4'd0);
   assign done     = pready_o;

   // Only CTRL and SCRATCH (idx[1]==0) are writable.
   assign wr_en = done && pwrite_i && mapped && !idx[1];

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      unique case (state)
         IDLE: begin
            if (psel_i && !penable_i) begin
               state_nx    = ACCESS;
               wait_cnt_nx = 4'(WAIT_CYCLES);
            end
         end
         ACCESS: begin
            if (!psel_i) begin
               state_nx = IDLE;
            end else if (penable_i) begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt_nx = wait_cnt - 4'd1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ctrl    <= 32'h0;
         scratch <= 32'h0;
         wcount  <= 32'h0;
      end else if (wr_en) begin
         if (idx[0]) begin
            scratch <= pwdata_i;
         end else begin
            ctrl <= pwdata_i;
         end
         wcount <= wcount + 32'd1;
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (done && !pwrite_i && mapped) begin
         unique case (idx)
            2'd0:    rdata = ctrl;
            2'd1:    rdata = scratch;
            2'd2:    rdata = status_i;
            default: rdata = wcount;
         endcase
      end
   end

   assign prdata_o = rdata;
   assign ctrl_o   = ctrl;

`ifdef APB_REG_SLAVE_PSLVERR_EN
   assign pslverr_o = done && (!mapped || (pwrite_i && idx[1]));
`else
   assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances (1, 0 and 3 wait states) checked
// against a register-map model with directed and random APB transfers.
module tb_apb_reg_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel[3];
   logic        penable[3];
   logic [7:0]  paddr[3];
   logic        pwrite[3];
   logic [31:0] pwdata[3];
   logic [31:0] prdata[3];
   logic        pready[3];
   logic        pslverr[3];
   logic [31:0] status[3];
   logic [31:0] ctrl_o[3];

   logic [31:0] m_ctrl[3];
   logic [31:0] m_scr[3];
   logic [31:0] m_wc[3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_reg_slave #(
         .ADDR_WIDTH  (8),
         .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 3))
      ) u_dut (
         .clk_i     (clk),
         .rst_n_i   (rst_n),
         .psel_i    (psel[g]),
         .penable_i (penable[g]),
         .paddr_i   (paddr[g]),
         .pwrite_i  (pwrite[g]),
         .pwdata_i  (pwdata[g]),
         .prdata_o  (prdata[g]),
         .pready_o  (pready[g]),
         .pslverr_o (pslverr[g]),
         .status_i  (status[g]),
         .ctrl_o    (ctrl_o[g])
      );
   end

   function automatic int wc(int d);
      case (d)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_ctrl[i] = 32'h0;
         m_scr[i]  = 32'h0;
         m_wc[i]   = 32'h0;
      end
   endfunction

   function automatic logic [31:0] exp_rd(int d, bit wr, logic [7:0] a);
      if (wr || a >= 8'h10) return 32'h0;
      case (a / 4)
         0:       return m_ctrl[d];
         1:       return m_scr[d];
         2:       return status[d];
         default: return m_wc[d];
      endcase
   endfunction

   function automatic bit exp_err(bit wr, logic [7:0] a);
`ifdef APB_REG_SLAVE_PSLVERR_EN
      return (a >= 8'h10) || (wr && a >= 8'h08);
`else
      return (wr && a > 8'hFF);
`endif
   endfunction

   function automatic void model_write(int d, logic [7:0] a, logic [31:0] v);
      if (a < 8'h08) begin
         if (a < 8'h04) m_ctrl[d] = v;
         else           m_scr[d]  = v;
         m_wc[d] = m_wc[d] + 32'd1;
      end
   endfunction

   // Called just after a rising edge; returns just after the completion edge.
   task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output int acc);
      bit rdy;
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = a;
      pwdata[d]  = wd;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      acc = 0;
      rdy = 1'b0;
      rd  = 32'h0;
      err = 1'b0;
      while (!rdy && acc < 20) begin
         @(negedge clk);
         acc++;
         rdy = pready[d];
         rd  = prdata[d];
         err = pslverr[d];
         if (!rdy) chk("wait_prdata", prdata[d], 32'h0);
         @(posedge clk); #1;
      end
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   task automatic do_xfer(int d, bit wr, logic [7:0] a, logic [31:0] wd);
      logic [31:0] rd, erd;
      logic        err;
      bit          eerr;
      int          acc;
      erd  = exp_rd(d, wr, a);
      eerr = exp_err(wr, a);
      xfer(d, wr, a, wd, rd, err, acc);
      chk("acc_cycles", 32'(acc), 32'(wc(d) + 1));
      chk("prdata", rd, erd);
      chk("pslverr", {31'h0, err}, {31'h0, eerr});
      if (wr) model_write(d, a, wd);
      chk("ctrl_o", ctrl_o[d], m_ctrl[d]);
   endtask

   initial begin
      int          d;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] v;
      int          r;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         psel[i]    = 1'b0;
         penable[i] = 1'b0;
         paddr[i]   = 8'h0;
         pwrite[i]  = 1'b0;
         pwdata[i]  = 32'h0;
         status[i]  = 32'h0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_pready", {31'h0, pready[i]}, 32'h0);
         chk("rst_pslverr", {31'h0, pslverr[i]}, 32'h0);
         chk("rst_prdata", prdata[i], 32'h0);
         chk("rst_ctrl", ctrl_o[i], 32'h0);
      end
      @(posedge clk); #1;

      // One wait state: write CTRL, then count reads back 1.
      do_xfer(0, 1'b1, 8'h00, 32'hA5A5_0001);
      chk("ctrl_visible", ctrl_o[0], 32'hA5A5_0001);
      do_xfer(0, 1'b0, 8'h0C, 32'h0);

      // Zero wait states, back-to-back write then read of SCRATCH.
      do_xfer(1, 1'b1, 8'h04, 32'hDEAD_BEEF);
      do_xfer(1, 1'b0, 8'h04, 32'h0);

      status[0] = 32'h1234_5678;
      do_xfer(0, 1'b0, 8'h08, 32'h0);

      // Unmapped and read-only writes must not count.
      do_xfer(0, 1'b1, 8'h10, 32'h1111_1111);
      do_xfer(0, 1'b1, 8'h08, 32'h2222_2222);
      do_xfer(0, 1'b1, 8'h0C, 32'h3333_3333);
      do_xfer(0, 1'b0, 8'h12, 32'h0);
      do_xfer(0, 1'b0, 8'h0C, 32'h0);

      // Three wait states: drop psel mid-wait, then a bare enable in IDLE.
      psel[2]    = 1'b1;
      penable[2] = 1'b0;
      pwrite[2]  = 1'b1;
      paddr[2]   = 8'h00;
      pwdata[2]  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      penable[2] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("abort_wait_pready", {31'h0, pready[2]}, 32'h0);
         @(posedge clk); #1;
      end
      psel[2]    = 1'b0;
      penable[2] = 1'b0;
      @(negedge clk);
      chk("abort_drop_pready", {31'h0, pready[2]}, 32'h0);
      @(posedge clk); #1;
      psel[2]    = 1'b1;
      penable[2] = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("idle_enable_pready", {31'h0, pready[2]}, 32'h0);
         @(posedge clk); #1;
      end
      psel[2]    = 1'b0;
      penable[2] = 1'b0;
      chk("abort_ctrl", ctrl_o[2], m_ctrl[2]);
      do_xfer(2, 1'b0, 8'h0C, 32'h0);
      do_xfer(2, 1'b1, 8'h00, 32'h0BAD_CAFE);

      // Reset asserted during the access phase of a CTRL write.
      psel[0]    = 1'b1;
      penable[0] = 1'b0;
      pwrite[0]  = 1'b1;
      paddr[0]   = 8'h00;
      pwdata[0]  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      psel[0]    = 1'b0;
      penable[0] = 1'b0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("midrst_ctrl", ctrl_o[i], 32'h0);
         chk("midrst_pready", {31'h0, pready[i]}, 32'h0);
      end
      @(posedge clk); #1;
      do_xfer(0, 1'b1, 8'h04, 32'h5A5A_5A5A);
      do_xfer(0, 1'b0, 8'h0C, 32'h0);

      // Random traffic across all instances.
      for (int n = 0; n < 80; n++) begin
         d  = int'($urandom_range(0, 2));
         wr = 1'($urandom);
         r  = int'($urandom_range(0, 7));
         if (r < 6) a = 8'($urandom_range(0, 15));
         else       a = 8'($urandom_range(16, 255));
         v = $urandom;
         status[d] = $urandom;
         do_xfer(d, wr, a, v);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         do_xfer(i, 1'b0, 8'h0C, 32'h0);
         do_xfer(i, 1'b0, 8'h04, 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
